ring_osc_freq_meter: RTL
========================

Name: ring_osc_freq_meter

Overview:
- Receive-side companion to the ring oscillator and its divider chain.
- Counts rising edges of an asynchronous oscillator signal (ring output or divided tap) over a fixed gate window of clk cycles.
- Publishes a saturating edge count per measurement, so ring frequency is readable in the system clock domain: f_osc = result * f_clk / 2^GATE_LOG2.
- Valid for f_osc < f_clk/2. Faster rings are measured through a divided tap.

Parameters:
- GATE_LOG2, default 10: gate window length is 2^GATE_LOG2 clk cycles. Legal range 2..20.
- CNT_W, default 16: width of the edge accumulator and of the result.
- SYNC_STAGES, default 2: flops in the osc_in synchronizer. Legal values 2..3.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- osc_in  in  1  asynchronous oscillator signal to be measured.
- start  in  1  level-sampled; high in IDLE begins a measurement.
- cont  in  1  continuous mode; sampled on the final gate cycle.
- result  out  CNT_W  count from the last completed measurement.
- valid  out  1  high once any measurement has completed since reset.
- done  out  1  single-cycle pulse when result updates.
- busy  out  1  high while a gate window is open.
- overflow  out  1  last result saturated.

Behaviour:
- Reset, sampled on the clk edge: state=IDLE; result=0, valid=0, done=0, busy=0, overflow=0. Gate counter, accumulator and synchronizer flops all cleared.
- Reset mid-measurement aborts it. No done pulse; result is cleared.
- Synchronizer: osc_in passes through SYNC_STAGES flops plus one history flop. rise = sync_last & ~hist. rise is registered-domain only.
- States: IDLE, GATE, plus a one-cycle done pulse that is not a separate state.
- IDLE, start=1 at edge k: state=GATE from k+1. gate_cnt=0, acc=0, busy=1.
- IDLE, start=0: hold.
- GATE, each cycle: if rise, acc <= sat(acc+1). acc saturates at 2^CNT_W-1 and never wraps. gate_cnt increments.
- GATE, final cycle (gate_cnt == 2^GATE_LOG2-1): a rise in this cycle is included. At the next edge:
  - result <= sat(acc + rise).
  - overflow <= saturated-or-would-exceed.
  - valid <= 1, done <= 1 for one cycle.
  - If cont=1: stay in GATE with gate_cnt=0, acc=0, busy stays 1. No idle gap, so no edge is lost between windows.
  - Else: state=IDLE, busy=0.
- Latency: done asserts exactly 2^GATE_LOG2 + 1 cycles after the start-sampling edge.
- Windows cover exactly 2^GATE_LOG2 rise-detection samples.
- start while busy is ignored. start held high in IDLE after done relaunches on the next cycle.
- Dropping cont mid-window only matters at the final cycle.
- result and overflow change only on done (or reset). They are stable between pulses.
- Rises arriving in synchronizer flops before start are counted if they emerge during GATE. This is an accepted ±1 quantisation; the bench tolerates ±1 only where stated.

Decomposition:
- Shared package ring_meas_pkg holds:
  - state enum (IDLE, GATE);
  - helper constant GATE_LEN = 2^GATE_LOG2 (as a localparam function);
  - saturating-increment function.
- One sub-module, osc_sync_edge: parameterised SYNC_STAGES synchronizer plus rise detector. Outputs rise; clocked by clk; synchronous rst.
- Counter and FSM stay in the top module.

Test Plan:
1. GATE_LOG2=6, osc_in period 8 clk (4 high/4 low), start pulse → done at start+65 cycles; result=8 (±1), overflow=0, valid=1, busy low after done.
2. osc_in held constant 0, then constant 1, single measurement each → result=0, overflow=0, done still pulses at start+65.
3. CNT_W=4, GATE_LOG2=6, osc_in period 4 clk (16 rises) → result=15, overflow=1. Then period 16 clk → result=4, overflow=0.
4. cont=1, osc_in period 8, GATE_LOG2=6 → done pulses every 64 cycles, each result=8, busy never drops. Clear cont → exactly one more done, then IDLE.
5. rst asserted at gate_cnt=30, after a prior result=8 → next cycle result=0, valid=0, busy=0, no done. New start then yields normal result.
6. start re-pulsed while busy at gate_cnt=10 → ignored: single done at the original start+65, result=8.

Source files
------------

// File: rtl/ring_meas_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter.
// Holds the FSM state encoding, the gate-length helper and a saturating increment.
package ring_meas_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    function automatic int unsigned gate_len(input int unsigned gate_log2);
        return 32'd1 << gate_log2;
    endfunction

    // Clamps at max_val instead of wrapping; callers zero-extend narrower counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/ring_osc_freq_meter_if.sv
// Control/result bundle of the ring-oscillator frequency meter.
// start is level-sampled only in IDLE, and done is a one-cycle pulse that coincides with the update of result and overflow.
interface ring_osc_freq_meter_if #(
    parameter int CNT_W = 16
);
    import ring_meas_pkg::*;

    logic             osc_in;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] result;
    logic             valid;
    logic             done;
    logic             busy;
    logic             overflow;
    state_t           dbg_state;

    modport master (
        output osc_in, start, cont,
        input  result, valid, done, busy, overflow, dbg_state
    );

    modport slave (
        input  osc_in, start, cont,
        output result, valid, done, busy, overflow, dbg_state
    );

endinterface

// File: rtl/osc_sync_edge.sv
// Synchronises the asynchronous oscillator input into clk and flags rising edges.
// rise is a combinational decode of the last sync flop against one history flop.
module osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Counts oscillator rising edges over a 2^GATE_LOG2-cycle gate window and publishes a saturating count.
// f_osc = result * f_clk / 2^GATE_LOG2, valid for f_osc < f_clk/2.
module ring_osc_freq_meter #(
    parameter int GATE_LOG2   = 10,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_osc_freq_meter_if.slave  bus
);
    import ring_meas_pkg::*;

    localparam logic [GATE_LOG2-1:0] GATE_LAST = GATE_LOG2'(gate_len(GATE_LOG2) - 1);
    localparam logic [GATE_LOG2-1:0] CNT_ONE   = GATE_LOG2'(1);
    localparam logic [CNT_W-1:0]     ACC_MAX   = '1;

    state_t               state;
    logic [GATE_LOG2-1:0] gate_cnt;
    logic [CNT_W-1:0]     acc;
    logic                 sat_seen;
    logic [CNT_W-1:0]     result;
    logic                 valid;
    logic                 done;
    logic                 busy;
    logic                 overflow;
    logic                 rise;
    logic [CNT_W-1:0]     acc_inc;
    logic                 would_sat;

    osc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_in (bus.osc_in),
        .rise   (rise)
    );

    assign acc_inc   = rise ? CNT_W'(sat_inc(32'(acc), 32'(ACC_MAX))) : acc;
    // A rise landing on an already-full accumulator is what marks the result as saturated.
    assign would_sat = rise && (acc == ACC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            acc      <= '0;
            sat_seen <= 1'b0;
            result   <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= GATE;
                        gate_cnt <= '0;
                        acc      <= '0;
                        sat_seen <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                GATE: begin
                    if (gate_cnt == GATE_LAST) begin
                        result   <= acc_inc;
                        overflow <= sat_seen | would_sat;
                        valid    <= 1'b1;
                        done     <= 1'b1;
                        gate_cnt <= '0;
                        acc      <= '0;
                        sat_seen <= 1'b0;
                        // Continuous mode rolls straight into the next window so no edge falls in a gap.
                        if (!bus.cont) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        acc      <= acc_inc;
                        sat_seen <= sat_seen | would_sat;
                        gate_cnt <= gate_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result    = result;
    assign bus.valid     = valid;
    assign bus.done      = done;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow;
    assign bus.dbg_state = state;

endmodule
